// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported unified memory between instruction fetch and load/store.
// MEM wins ties; each access is a Mem_Req/Mem_Ready handshake with a bounded wait.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              IF_Req,
  input  logic [ADDR_W-1:0] IF_Addr,
  input  logic              IF_Flush,
  input  logic              MEM_Read,
  input  logic              MEM_Write,
  input  logic [ADDR_W-1:0] MEM_Addr,
  input  logic [DATA_W-1:0] MEM_WData,
  output logic [DATA_W-1:0] IF_Instruction,
  output logic              IF_Valid,
  output logic [DATA_W-1:0] MEM_RData,
  output logic              MEM_Done,
  output logic              Stall_IF,
  output logic              Stall_MEM,
  output logic              Bus_Err,
  output logic              Mem_Req,
  output logic              Mem_WE,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [DATA_W-1:0] Mem_WData,
  input  logic              Mem_Ready,
  input  logic [DATA_W-1:0] Mem_RData
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SERVE_MEM = 2'd1,
    SERVE_IF  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   if_instr_q, if_instr_d;
  logic                if_valid_q, if_valid_d;
  logic [DATA_W-1:0]   mem_rdata_q, mem_rdata_d;
  logic                mem_done_q, mem_done_d;
  logic                bus_err_q, bus_err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                drop_q, drop_d;

  logic                mem_pending_c;
  logic                if_pending_c;
  logic                handshake_c;
  logic                timeout_c;
  logic                drop_c;

  // A requester whose done pulse is showing is still holding its request; skip it this cycle.
  assign mem_pending_c = (MEM_Read | MEM_Write) & ~mem_done_q;
  assign if_pending_c  = IF_Req & ~IF_Flush & ~if_valid_q;
  assign handshake_c   = mem_req_q & Mem_Ready;
  assign timeout_c     = ~Mem_Ready & (cnt_q == CNT_W'(TIMEOUT - 1));
  assign drop_c        = drop_q | IF_Flush;

  // State and registered outputs
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_instr_q  <= '0;
      if_valid_q  <= 1'b0;
      mem_rdata_q <= '0;
      mem_done_q  <= 1'b0;
      bus_err_q   <= 1'b0;
      cnt_q       <= '0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_instr_q  <= if_instr_d;
      if_valid_q  <= if_valid_d;
      mem_rdata_q <= mem_rdata_d;
      mem_done_q  <= mem_done_d;
      bus_err_q   <= bus_err_d;
      cnt_q       <= cnt_d;
      drop_q      <= drop_d;
    end
  end

  // Arbitration, handshake and timeout sequencing
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_instr_d  = if_instr_q;
    if_valid_d  = 1'b0;
    mem_rdata_d = mem_rdata_q;
    mem_done_d  = 1'b0;
    bus_err_d   = 1'b0;
    cnt_d       = cnt_q;
    drop_d      = drop_q;

    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        drop_d = 1'b0;
        if (mem_pending_c) begin
          mem_addr_d  = MEM_Addr;
          mem_wdata_d = MEM_WData;
          mem_we_d    = MEM_Write;
          mem_req_d   = 1'b1;
          state_d     = SERVE_MEM;
        end else if (if_pending_c) begin
          mem_addr_d = IF_Addr;
          mem_we_d   = 1'b0;
          mem_req_d  = 1'b1;
          state_d    = SERVE_IF;
        end
      end

      SERVE_MEM: begin
        if (handshake_c) begin
          if (!mem_we_q) begin
            mem_rdata_d = Mem_RData;
          end
          mem_req_d  = 1'b0;
          mem_done_d = 1'b1;
          state_d    = IDLE;
        end else if (timeout_c) begin
          mem_rdata_d = '0;
          mem_req_d   = 1'b0;
          mem_done_d  = 1'b1;
          bus_err_d   = 1'b1;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      SERVE_IF: begin
        // A flushed fetch still finishes on the bus but is never reported.
        drop_d = drop_c;
        if (handshake_c) begin
          if (!drop_c) begin
            if_instr_d = Mem_RData;
            if_valid_d = 1'b1;
          end
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end else if (timeout_c) begin
          if (!drop_c) begin
            if_instr_d = '0;
            if_valid_d = 1'b1;
          end
          mem_req_d = 1'b0;
          bus_err_d = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  assign Stall_IF  = (IF_Req & ~IF_Valid & ~IF_Flush) | (state_q == SERVE_MEM);
  assign Stall_MEM = (MEM_Read | MEM_Write) & ~MEM_Done;

  assign Mem_Req        = mem_req_q;
  assign Mem_WE         = mem_we_q;
  assign Mem_Addr       = mem_addr_q;
  assign Mem_WData      = mem_wdata_q;
  assign IF_Instruction = if_instr_q;
  assign IF_Valid       = if_valid_q;
  assign MEM_RData      = mem_rdata_q;
  assign MEM_Done       = mem_done_q;
  assign Bus_Err        = bus_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, fetch, conflict, store, flush, timeout.
module tb_mem_port_arbiter;

  logic        CLK;
  logic        RESET;
  logic        IF_Req;
  logic [31:0] IF_Addr;
  logic        IF_Flush;
  logic        MEM_Read;
  logic        MEM_Write;
  logic [31:0] MEM_Addr;
  logic [31:0] MEM_WData;
  logic [31:0] IF_Instruction;
  logic        IF_Valid;
  logic [31:0] MEM_RData;
  logic        MEM_Done;
  logic        Stall_IF;
  logic        Stall_MEM;
  logic        Bus_Err;
  logic        Mem_Req;
  logic        Mem_WE;
  logic [31:0] Mem_Addr;
  logic [31:0] Mem_WData;
  logic        Mem_Ready;
  logic [31:0] Mem_RData;

  int passed = 0;
  int total  = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(15)) dut (
    .CLK(CLK), .RESET(RESET),
    .IF_Req(IF_Req), .IF_Addr(IF_Addr), .IF_Flush(IF_Flush),
    .MEM_Read(MEM_Read), .MEM_Write(MEM_Write), .MEM_Addr(MEM_Addr), .MEM_WData(MEM_WData),
    .IF_Instruction(IF_Instruction), .IF_Valid(IF_Valid),
    .MEM_RData(MEM_RData), .MEM_Done(MEM_Done),
    .Stall_IF(Stall_IF), .Stall_MEM(Stall_MEM), .Bus_Err(Bus_Err),
    .Mem_Req(Mem_Req), .Mem_WE(Mem_WE), .Mem_Addr(Mem_Addr), .Mem_WData(Mem_WData),
    .Mem_Ready(Mem_Ready), .Mem_RData(Mem_RData)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  initial begin
    RESET = 1'b0; IF_Req = 1'b0; IF_Addr = '0; IF_Flush = 1'b0;
    MEM_Read = 1'b0; MEM_Write = 1'b0; MEM_Addr = '0; MEM_WData = '0;
    Mem_Ready = 1'b0; Mem_RData = '0;
    cyc(); cyc();
    chk1("rst_mem_req", Mem_Req, 1'b0);
    chk1("rst_if_valid", IF_Valid, 1'b0);
    chk1("rst_mem_done", MEM_Done, 1'b0);
    chk1("rst_bus_err", Bus_Err, 1'b0);
    chk32("rst_mem_addr", Mem_Addr, 32'h0);
    chk32("rst_if_instr", IF_Instruction, 32'h0);
    RESET = 1'b1;
    cyc();

    // Zero-wait fetch
    IF_Req = 1'b1; IF_Addr = 32'h4; Mem_Ready = 1'b1; Mem_RData = 32'h01064820;
    #1;
    chk1("f0_stall_if", Stall_IF, 1'b1);
    chk1("f0_mem_req", Mem_Req, 1'b0);
    cyc();
    chk1("f1_mem_req", Mem_Req, 1'b1);
    chk32("f1_mem_addr", Mem_Addr, 32'h4);
    chk1("f1_mem_we", Mem_WE, 1'b0);
    chk1("f1_stall_if", Stall_IF, 1'b1);
    chk1("f1_if_valid", IF_Valid, 1'b0);
    cyc();
    chk1("f2_if_valid", IF_Valid, 1'b1);
    chk32("f2_if_instr", IF_Instruction, 32'h01064820);
    chk1("f2_mem_req", Mem_Req, 1'b0);
    chk1("f2_stall_if", Stall_IF, 1'b0);
    IF_Req = 1'b0; Mem_Ready = 1'b0;
    cyc();
    chk1("f3_if_valid", IF_Valid, 1'b0);
    chk1("f3_mem_req", Mem_Req, 1'b0);

    // Same-cycle conflict: MEM first, fetch granted on MEM_Done cycle
    IF_Req = 1'b1; IF_Addr = 32'h8; MEM_Read = 1'b1; MEM_Addr = 32'h10; Mem_RData = 32'hC;
    #1;
    chk1("c0_stall_if", Stall_IF, 1'b1);
    chk1("c0_stall_mem", Stall_MEM, 1'b1);
    cyc();
    chk1("c1_mem_req", Mem_Req, 1'b1);
    chk32("c1_mem_addr", Mem_Addr, 32'h10);
    chk1("c1_mem_we", Mem_WE, 1'b0);
    chk1("c1_stall_if", Stall_IF, 1'b1);
    cyc();
    chk1("c2_mem_req", Mem_Req, 1'b1);
    chk1("c2_stall_if", Stall_IF, 1'b1);
    cyc();
    Mem_Ready = 1'b1;
    cyc();
    chk1("c4_mem_done", MEM_Done, 1'b1);
    chk32("c4_mem_rdata", MEM_RData, 32'hC);
    chk1("c4_stall_if", Stall_IF, 1'b1);
    chk1("c4_stall_mem", Stall_MEM, 1'b0);
    chk1("c4_mem_req", Mem_Req, 1'b0);
    MEM_Read = 1'b0; Mem_RData = 32'h8C0000AA;
    cyc();
    chk1("c5_mem_req", Mem_Req, 1'b1);
    chk32("c5_mem_addr", Mem_Addr, 32'h8);
    chk1("c5_mem_done", MEM_Done, 1'b0);
    cyc();
    chk1("c6_if_valid", IF_Valid, 1'b1);
    chk32("c6_if_instr", IF_Instruction, 32'h8C0000AA);
    IF_Req = 1'b0; Mem_Ready = 1'b0;
    cyc();

    // Store with two wait cycles
    MEM_Write = 1'b1; MEM_Addr = 32'h20; MEM_WData = 32'hDEADBEEF;
    cyc();
    chk1("s1_mem_req", Mem_Req, 1'b1);
    chk1("s1_mem_we", Mem_WE, 1'b1);
    chk32("s1_mem_wdata", Mem_WData, 32'hDEADBEEF);
    chk32("s1_mem_addr", Mem_Addr, 32'h20);
    cyc();
    chk1("s2_mem_we", Mem_WE, 1'b1);
    chk32("s2_mem_wdata", Mem_WData, 32'hDEADBEEF);
    Mem_Ready = 1'b1; Mem_RData = 32'h12345678;
    cyc();
    chk1("s3_mem_done", MEM_Done, 1'b1);
    chk32("s3_mem_rdata", MEM_RData, 32'hC);
    chk1("s3_mem_req", Mem_Req, 1'b0);
    MEM_Write = 1'b0; Mem_Ready = 1'b0;
    cyc();
    chk1("s4_mem_done", MEM_Done, 1'b0);

    // Flush while the fetch is in flight
    IF_Req = 1'b1; IF_Addr = 32'h40;
    cyc();
    chk1("fl1_mem_req", Mem_Req, 1'b1);
    chk32("fl1_mem_addr", Mem_Addr, 32'h40);
    IF_Flush = 1'b1; IF_Req = 1'b0;
    #1;
    chk1("fl1_stall_if", Stall_IF, 1'b0);
    cyc();
    IF_Flush = 1'b0; Mem_Ready = 1'b1; Mem_RData = 32'hFFFFFFFF;
    cyc();
    chk1("fl3_if_valid", IF_Valid, 1'b0);
    chk32("fl3_if_instr", IF_Instruction, 32'h8C0000AA);
    chk1("fl3_mem_req", Mem_Req, 1'b0);
    Mem_Ready = 1'b0;
    cyc();
    chk1("fl4_if_valid", IF_Valid, 1'b0);
    chk1("fl4_mem_req", Mem_Req, 1'b0);

    // Flush in IDLE blocks the grant
    IF_Req = 1'b1; IF_Flush = 1'b1;
    cyc();
    chk1("fi_mem_req", Mem_Req, 1'b0);
    IF_Req = 1'b0; IF_Flush = 1'b0;
    cyc();

    // Timeout on a load that never gets Mem_Ready
    MEM_Read = 1'b1; MEM_Addr = 32'h30;
    cyc();
    for (int i = 0; i < 15; i++) begin
      chk1("to_wait_mem_req", Mem_Req, 1'b1);
      chk1("to_wait_bus_err", Bus_Err, 1'b0);
      cyc();
    end
    chk1("to_mem_req", Mem_Req, 1'b0);
    chk1("to_bus_err", Bus_Err, 1'b1);
    chk1("to_mem_done", MEM_Done, 1'b1);
    chk32("to_mem_rdata", MEM_RData, 32'h0);
    MEM_Read = 1'b0;
    cyc();
    chk1("to_bus_err_end", Bus_Err, 1'b0);
    chk1("to_mem_done_end", MEM_Done, 1'b0);

    // Normal load after the abort
    MEM_Read = 1'b1; MEM_Addr = 32'h34; Mem_Ready = 1'b1; Mem_RData = 32'h000055AA;
    cyc();
    chk1("pt_mem_req", Mem_Req, 1'b1);
    chk32("pt_mem_addr", Mem_Addr, 32'h34);
    cyc();
    chk1("pt_mem_done", MEM_Done, 1'b1);
    chk32("pt_mem_rdata", MEM_RData, 32'h000055AA);
    chk1("pt_bus_err", Bus_Err, 1'b0);
    MEM_Read = 1'b0;
    cyc();

    // Read and write together behave as a write
    MEM_Read = 1'b1; MEM_Write = 1'b1; MEM_Addr = 32'h38; MEM_WData = 32'hA5A5A5A5;
    Mem_RData = 32'h77777777;
    cyc();
    chk1("rw_mem_we", Mem_WE, 1'b1);
    chk32("rw_mem_wdata", Mem_WData, 32'hA5A5A5A5);
    cyc();
    chk1("rw_mem_done", MEM_Done, 1'b1);
    chk32("rw_mem_rdata", MEM_RData, 32'h000055AA);
    MEM_Read = 1'b0; MEM_Write = 1'b0; Mem_Ready = 1'b0;
    cyc();

    // Reset in the middle of SERVE_MEM
    MEM_Read = 1'b1; MEM_Addr = 32'h50;
    cyc();
    chk1("rm_mem_req", Mem_Req, 1'b1);
    RESET = 1'b0;
    #1;
    chk1("rm_mem_req_rst", Mem_Req, 1'b0);
    chk32("rm_mem_addr_rst", Mem_Addr, 32'h0);
    chk32("rm_mem_rdata_rst", MEM_RData, 32'h0);
    chk1("rm_mem_we_rst", Mem_WE, 1'b0);
    chk32("rm_if_instr_rst", IF_Instruction, 32'h0);
    MEM_Read = 1'b0; Mem_Ready = 1'b1;
    cyc();
    RESET = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk1("rm_no_done", MEM_Done, 1'b0);
      chk1("rm_no_req", Mem_Req, 1'b0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
